// File: rtl/modulator_pam_n.sv
`default_nettype none
// ============================================================================
// Module   : modulator_pam_n
// Purpose  : Serialises FIFO samples into PAM symbols sent as PWM pulses,
//            MSB symbol first, with bit clock, symbol strobe and frame sync.
//            Prefetches the next sample during the last symbol so that
//            consecutive samples are sent back-to-back.
// Options  : PAM_GRAY_MAP_EN - when defined, symbol bits are Gray-coded into
//            the amplitude level; otherwise the level is natural binary.
// Revision : 1.0 - initial release
// ============================================================================
module modulator_pam_n #(
    parameter int SAMPLE_WIDTH    = 8,
    parameter int BITS_PER_SYMBOL = 2,
    parameter int SYMB_PERIOD     = 1200,
    parameter int PWM_STEP        = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    empty,
    output logic                    read,
    output logic                    pwm,
    output logic                    nsync,
    output logic                    bclk,
    output logic                    symb_clk
);

    localparam int C_PWM_PERIOD = ((1 << BITS_PER_SYMBOL) + 1) * PWM_STEP;
    localparam int C_NSYM       = SAMPLE_WIDTH / BITS_PER_SYMBOL;
    localparam int C_SC_W       = $clog2(SYMB_PERIOD);
    localparam int C_PC_W       = $clog2(C_PWM_PERIOD);
    localparam int C_SIDX_W     = (C_NSYM > 1) ? $clog2(C_NSYM) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [C_SC_W-1:0]            r_sc;
    logic [C_PC_W-1:0]            r_pc;
    logic [C_SIDX_W-1:0]          r_sidx;
    logic [SAMPLE_WIDTH-1:0]      r_shreg;
    logic                         r_pending;
    logic                         r_armed;

    logic                         w_send;
    logic                         w_last_sym;
    logic                         w_sc_pre;
    logic                         w_sc_last;
    logic [BITS_PER_SYMBOL-1:0]   w_sym;
    logic [BITS_PER_SYMBOL-1:0]   w_level;
    logic [C_PC_W-1:0]            w_thresh;

    assign w_send     = (r_state == S_SEND);
    assign w_last_sym = (r_sidx == C_SIDX_W'(C_NSYM - 1));
    assign w_sc_pre   = (r_sc == C_SC_W'(SYMB_PERIOD - 2));
    assign w_sc_last  = (r_sc == C_SC_W'(SYMB_PERIOD - 1));

    // State register; reset aborts any transfer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and read strobe; r_armed blocks a read in the first cycle out of reset.
    always_comb begin
        w_state_nxt = r_state;
        read        = 1'b0;
        case (r_state)
            S_IDLE: begin
                read = r_armed & enable & ~empty;
                if (read) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (w_last_sym && w_sc_pre) begin
                    read = r_armed & enable & ~empty;
                end
                if (w_last_sym && w_sc_last && !r_pending) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Symbol/PWM counters, shift register and prefetch flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sc      <= '0;
            r_pc      <= '0;
            r_sidx    <= '0;
            r_shreg   <= '0;
            r_pending <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                S_FETCH: begin
                    r_shreg   <= sample;
                    r_sc      <= '0;
                    r_pc      <= '0;
                    r_sidx    <= '0;
                    r_pending <= 1'b0;
                end
                S_SEND: begin
                    if (read) begin
                        r_pending <= 1'b1;
                    end
                    if (w_sc_last) begin
                        r_sc <= '0;
                        r_pc <= '0;
                        if (w_last_sym) begin
                            r_sidx    <= '0;
                            r_pending <= 1'b0;
                            if (r_pending) begin
                                r_shreg <= sample;
                            end
                        end else begin
                            r_sidx  <= r_sidx + 1'b1;
                            r_shreg <= r_shreg << BITS_PER_SYMBOL;
                        end
                    end else begin
                        r_sc <= r_sc + 1'b1;
                        r_pc <= (r_pc == C_PC_W'(C_PWM_PERIOD - 1)) ? '0 : r_pc + 1'b1;
                    end
                end
                default: begin
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    // Amplitude level of the current symbol and its PWM high-time threshold.
    always_comb begin
        w_sym = r_shreg[SAMPLE_WIDTH-1 -: BITS_PER_SYMBOL];
`ifdef PAM_GRAY_MAP_EN
        w_level = w_sym ^ (w_sym >> 1);
`else
        w_level = w_sym;
`endif
        w_thresh = C_PC_W'((32'(w_level) + 32'd1) * 32'(PWM_STEP));
    end

    // Registered-state output decode; all idle values outside SEND.
    always_comb begin
        pwm      = w_send && (r_pc < w_thresh);
        symb_clk = w_send && (r_sc == '0);
        bclk     = w_send && (r_sc < C_SC_W'(SYMB_PERIOD / 2));
        nsync    = !(w_send && (r_sc == '0) && (r_sidx == '0));
    end

endmodule
`default_nettype wire
